l1_event_buffer: RTL and testbench

//  Downstream stage of the circular L1 latency buffer. On every delayed L1A it captures the
//  hit flag and 29-bit TDC word (TOA/TOT/CAL) the buffer presents, tags it with an 8-bit L1A

---
 rtl/etroc2_readout_pkg.sv | 19 +
 rtl/l1_event_fifo_mem.sv | 40 ++++
 rtl/l1_event_buffer.sv | 119 +++++++++++
 tb/tb_l1_event_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/etroc2_readout_pkg.sv
// Shared readout constants: TDC word width, L1A tag width, event-word layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package etroc2_readout_pkg;

  // TDC word from the circular buffer (TOA/TOT/CAL, hit bit already stripped)
  localparam int TDC_DATA_WIDTH = 29;

  // L1A event tag; wraps modulo 2**L1CNT_WIDTH
  localparam int L1CNT_WIDTH = 8;

  // Queued event word: {l1Tag, hit, data}
  localparam int EVT_WORD_WIDTH = L1CNT_WIDTH + 1 + TDC_DATA_WIDTH;

  // Dropped-L1A counter width and its saturation value
  localparam int              DROP_CNT_WIDTH = 8;
  localparam logic [7:0]      DROP_CNT_MAX   = 8'hFF;

endpackage

// File: rtl/l1_event_fifo_mem.sv
// Event FIFO storage: 2**ADDR_WIDTH x WORD_WIDTH registers, one sync write port, one comb read port.
// Latency: write visible on rdData the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner of the pointers decides when writing is legal.
//
// Ports:
//   clk, reset      clock and async active-low reset (clears every entry to zero)
//   wrEn/wrAddr/wrData  write port, captured on posedge
//   rdAddr/rdData       combinational read port
module l1_event_fifo_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 38
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [WORD_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [WORD_WIDTH-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Entries are cleared on reset so dout reads zero out of reset and never
  // exposes stale events after a mid-run reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/l1_event_buffer.sv
// Captures {l1Tag, hit, data} on each delayed L1A into a 16-deep FWFT FIFO drained by the frame builder.
// Latency: word written at edge N is on dout with doutValid=1 right after edge N.
// Backpressure: rdEn/doutValid handshake; when full with no pop the L1A is dropped and counted.
//
// Ports:
//   clk, reset       40 MHz bunch clock; async active-low reset
//   l1aIn/hitIn/dataIn  delayed L1A and the selected buffer cell's hit flag and TDC word
//   rdEn             consumer ready; pop when rdEn & doutValid
//   clrOverflow      sync pulse clearing overflowFlag and dropCount
//   dout/doutValid   head-of-queue event word and not-empty
//   full/wordCount   occupancy status
//   overflowFlag/dropCount  sticky drop flag and saturating drop counter
//   l1Count          tag the next L1A (accepted or dropped) will receive
module l1_event_buffer
  import etroc2_readout_pkg::*;
#(
  parameter int DATA_WIDTH  = etroc2_readout_pkg::TDC_DATA_WIDTH,
  parameter int DEPTH_LOG2  = 4,
  parameter int L1CNT_WIDTH = etroc2_readout_pkg::L1CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                l1aIn,
  input  logic                                hitIn,
  input  logic [DATA_WIDTH-1:0]               dataIn,
  input  logic                                rdEn,
  input  logic                                clrOverflow,
  output logic [L1CNT_WIDTH+1+DATA_WIDTH-1:0] dout,
  output logic                                doutValid,
  output logic                                full,
  output logic [DEPTH_LOG2:0]                 wordCount,
  output logic                                overflowFlag,
  output logic [DROP_CNT_WIDTH-1:0]           dropCount,
  output logic [L1CNT_WIDTH-1:0]              l1Count
);

  localparam int                     WORD_WIDTH  = L1CNT_WIDTH + 1 + DATA_WIDTH;
  localparam logic [DEPTH_LOG2:0]    DEPTH_WORDS = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]    CNT_ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [L1CNT_WIDTH-1:0] TAG_ONE     = L1CNT_WIDTH'(1);

  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [WORD_WIDTH-1:0] wrWord;
  logic                  pop;
  logic                  wrEn;
  logic                  drop;

  assign doutValid = (wordCount != '0);
  assign full      = (wordCount == DEPTH_WORDS);

  assign pop  = rdEn & doutValid;
  // A pop in the same cycle frees the slot at rdPtr, so a full FIFO can still
  // accept; when full wrPtr == rdPtr and the new word replaces the one leaving.
  assign wrEn = l1aIn & (~full | pop);
  assign drop = l1aIn & full & ~pop;

  // Empty events are still queued so every L1A yields exactly one entry.
  assign wrWord = {l1Count, hitIn, (hitIn ? dataIn : {DATA_WIDTH{1'b0}})};

  l1_event_fifo_mem #(
    .ADDR_WIDTH (DEPTH_LOG2),
    .WORD_WIDTH (WORD_WIDTH)
  ) uMem (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (wrWord),
    .rdAddr (rdPtr),
    .rdData (dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      wordCount <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      unique case ({wrEn, pop})
        2'b10:   wordCount <= wordCount + CNT_ONE;
        2'b01:   wordCount <= wordCount - CNT_ONE;
        default: wordCount <= wordCount;
      endcase
    end
  end

  // Tag advances on every L1A, so gaps in tags downstream reveal drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1Count <= '0;
    end else if (l1aIn) begin
      l1Count <= l1Count + TAG_ONE;
    end
  end

  // A drop coinciding with a clear wins: the clear empties the count and the
  // drop is then the first one recorded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflowFlag <= 1'b0;
      dropCount    <= '0;
    end else if (drop) begin
      overflowFlag <= 1'b1;
      if (clrOverflow) begin
        dropCount <= DROP_CNT_WIDTH'(1);
      end else if (dropCount != DROP_CNT_MAX) begin
        dropCount <= dropCount + DROP_CNT_WIDTH'(1);
      end
    end else if (clrOverflow) begin
      overflowFlag <= 1'b0;
      dropCount    <= '0;
    end
  end

endmodule

// File: tb/tb_l1_event_buffer.sv
// Self-checking bench for l1_event_buffer: directed steps plus randomized traffic
// against a queue-based reference model of the event buffer.
// Inputs change 1 time unit after posedge; outputs are checked at that point.
module tb_l1_event_buffer;

  localparam int DW = 29;
  localparam int DL = 4;
  localparam int CW = 8;
  localparam int WW = CW + 1 + DW;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          l1aIn = 1'b0;
  logic          hitIn = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic          rdEn = 1'b0;
  logic          clrOverflow = 1'b0;
  logic [WW-1:0] dout;
  logic          doutValid;
  logic          full;
  logic [DL:0]   wordCount;
  logic          overflowFlag;
  logic [7:0]    dropCount;
  logic [CW-1:0] l1Count;

  l1_event_buffer #(
    .DATA_WIDTH  (DW),
    .DEPTH_LOG2  (DL),
    .L1CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .l1aIn        (l1aIn),
    .hitIn        (hitIn),
    .dataIn       (dataIn),
    .rdEn         (rdEn),
    .clrOverflow  (clrOverflow),
    .dout         (dout),
    .doutValid    (doutValid),
    .full         (full),
    .wordCount    (wordCount),
    .overflowFlag (overflowFlag),
    .dropCount    (dropCount),
    .l1Count      (l1Count)
  );

  always #12 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words, tag counter, drop accounting.
  logic [WW-1:0] mq[$];
  int            mL1   = 0;
  int            mDrop = 0;
  bit            mFlag = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    check("valid", 64'(doutValid), 64'(mq.size() != 0));
    check("wordCount", 64'(wordCount), 64'(mq.size()));
    check("countBound", 64'(wordCount <= DEPTH), 64'd1);
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("overflowFlag", 64'(overflowFlag), 64'(mFlag));
    check("dropCount", 64'(dropCount), 64'(mDrop));
    check("l1Count", 64'(l1Count), 64'(mL1));
    if (mq.size() != 0) check("doutHead", 64'(dout), 64'(mq[0]));
  endtask

  // Apply the current inputs to the model, clock the DUT, compare everything.
  task automatic tick();
    bit            pop;
    bit            space;
    bit            dropped;
    logic [CW-1:0] tagv;
    logic [WW-1:0] w;
    pop     = rdEn && (mq.size() != 0);
    space   = (mq.size() < DEPTH) || pop;
    dropped = 1'b0;
    if (pop) w = mq.pop_front();
    if (l1aIn) begin
      tagv = mL1[CW-1:0];
      if (space) begin
        mq.push_back({tagv, hitIn, (hitIn ? dataIn : {DW{1'b0}})});
      end else begin
        dropped = 1'b1;
        mFlag   = 1'b1;
        mDrop   = clrOverflow ? 1 : ((mDrop < 255) ? mDrop + 1 : 255);
      end
      mL1 = (mL1 + 1) % 256;
    end
    if (clrOverflow && !dropped) begin
      mFlag = 1'b0;
      mDrop = 0;
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    reset       = 1'b0;
    l1aIn       = 1'b0;
    hitIn       = 1'b0;
    rdEn        = 1'b0;
    clrOverflow = 1'b0;
    dataIn      = '0;
    mq.delete();
    mL1   = 0;
    mDrop = 0;
    mFlag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] expWord;

    // 1: reset state
    doReset();
    check("rstValid", 64'(doutValid), 64'd0);
    check("rstWordCount", 64'(wordCount), 64'd0);
    check("rstL1Count", 64'(l1Count), 64'd0);
    check("rstOverflow", 64'(overflowFlag), 64'd0);
    check("rstFull", 64'(full), 64'd0);
    check("rstDout", 64'(dout), 64'd0);

    // 2: single hit event, then pop it
    l1aIn = 1'b1; hitIn = 1'b1; dataIn = 29'h0ABCDEF;
    tick();
    l1aIn = 1'b0;
    expWord = {8'h00, 1'b1, 29'h0ABCDEF};
    check("singleDout", 64'(dout), 64'(expWord));
    check("singleValid", 64'(doutValid), 64'd1);
    check("singleCount", 64'(wordCount), 64'd1);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check("singlePopValid", 64'(doutValid), 64'd0);

    // rdEn while empty must not disturb anything
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check("emptyReadCount", 64'(wordCount), 64'd0);

    // 3: no-hit L1A forces data field to zero
    l1aIn = 1'b1; hitIn = 1'b0; dataIn = 29'h1FFFFFFF;
    tick();
    l1aIn = 1'b0;
    expWord = {8'h01, 1'b0, 29'h0};
    check("noHitDout", 64'(dout), 64'(expWord));
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;

    // 4: fill, overflow by two, clear-vs-drop, clear, drain in order
    doReset();
    l1aIn = 1'b1; hitIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dataIn = DW'(i * 7 + 3);
      tick();
    end
    check("fillFull", 64'(full), 64'd1);
    repeat (2) tick();
    check("ovfDropCount", 64'(dropCount), 64'd2);
    check("ovfFlag", 64'(overflowFlag), 64'd1);
    check("ovfL1Count", 64'(l1Count), 64'd18);
    clrOverflow = 1'b1;
    tick();
    check("clrDropCount", 64'(dropCount), 64'd1);
    check("clrDropFlag", 64'(overflowFlag), 64'd1);
    l1aIn = 1'b0;
    tick();
    clrOverflow = 1'b0;
    check("clrCount", 64'(dropCount), 64'd0);
    check("clrFlag", 64'(overflowFlag), 64'd0);
    rdEn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drainTag", 64'(dout[WW-1 -: CW]), 64'(i));
      tick();
    end
    rdEn = 1'b0;
    check("drainEmpty", 64'(doutValid), 64'd0);

    // 5: full with simultaneous pop and write
    doReset();
    l1aIn = 1'b1; hitIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dataIn = DW'(32'h100 + i);
      tick();
    end
    rdEn = 1'b1;
    tick();
    l1aIn = 1'b0;
    check("fullPopWrCount", 64'(wordCount), 64'd16);
    check("fullPopWrDrop", 64'(dropCount), 64'd0);
    for (int i = 0; i < 16; i++) begin
      check("fullPopWrTag", 64'(dout[WW-1 -: CW]), 64'(i + 1));
      tick();
    end
    rdEn = 1'b0;

    // dropCount saturation
    doReset();
    l1aIn = 1'b1; hitIn = 1'b0;
    repeat (16 + 260) tick();
    l1aIn = 1'b0;
    check("satDropCount", 64'(dropCount), 64'd255);
    check("satL1Count", 64'(l1Count), 64'd20);

    // 6: randomized traffic, tag wrap, then a burst that forces drops
    doReset();
    for (int c = 0; c < 2000; c++) begin
      l1aIn       = ((c % 3) == 0);
      hitIn       = 1'($urandom_range(0, 1));
      dataIn      = DW'((c * 32'h9E37) ^ 32'h1234567);
      rdEn        = 1'($urandom_range(0, 1));
      clrOverflow = ($urandom_range(0, 199) == 0);
      tick();
    end
    for (int c = 0; c < 300; c++) begin
      l1aIn       = 1'b1;
      hitIn       = 1'($urandom_range(0, 1));
      dataIn      = DW'($urandom);
      rdEn        = ($urandom_range(0, 3) == 0);
      clrOverflow = ($urandom_range(0, 49) == 0);
      tick();
    end
    clrOverflow = 1'b0;
    rdEn        = 1'b0;
    l1aIn       = 1'b1;
    repeat (4) tick();

    // Reset mid-run: queue empties within the same cycle
    reset = 1'b0;
    #1;
    check("midRstValid", 64'(doutValid), 64'd0);
    check("midRstCount", 64'(wordCount), 64'd0);
    check("midRstL1Count", 64'(l1Count), 64'd0);
    check("midRstDout", 64'(dout), 64'd0);
    doReset();
    l1aIn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
